// File: rtl/demux832.sv
// One-to-eight buffered word distributor: each accepted word is steered by in_sel
// into a single-entry per-channel buffer that drains under its own valid/ready handshake.
module demux832 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data,
  output logic [15:0]        acc_cnt
);

  logic [7:0]       full_r;
  logic [WIDTH-1:0] data_r [8];
  logic [15:0]      acc_cnt_r;
  logic [7:0]       push_s;
  logic [7:0]       pop_s;

  // A slot can take a word if it is empty or is being drained this same cycle.
  assign in_ready = ~full_r[in_sel] | out_ready[in_sel];
  assign pop_s    = full_r & out_ready;

  // One-hot push vector for the selected channel.
  always_comb begin
    push_s = 8'h00;
    if (in_valid && in_ready) begin
      push_s[in_sel] = 1'b1;
    end else begin
      push_s = 8'h00;
    end
  end

  // Per-channel EMPTY/FULL buffers and the acceptance counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_r    <= 8'h00;
      acc_cnt_r <= 16'h0000;
      for (int k = 0; k < 8; k++) begin
        data_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (push_s[k]) begin
          // Push wins over a simultaneous pop so the slot streams at full rate.
          data_r[k] <= in_data;
          full_r[k] <= 1'b1;
        end else if (pop_s[k]) begin
          full_r[k] <= 1'b0;
        end else begin
          full_r[k] <= full_r[k];
        end
      end
      if (|push_s) begin
        acc_cnt_r <= acc_cnt_r + 16'h0001;
      end else begin
        acc_cnt_r <= acc_cnt_r;
      end
    end
  end

  // Flatten the buffer array onto the output bus.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < 8; k++) begin
      out_data[k*WIDTH +: WIDTH] = data_r[k];
    end
  end

  assign out_valid = full_r;
  assign acc_cnt   = acc_cnt_r;

endmodule

// File: tb/tb_demux832.sv
// Randomized and directed bench for demux832, checked against a per-channel
// queue model of delivered words.
module tb_demux832;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_sel;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [255:0] out_data;
  logic [15:0]  acc_cnt;

  int checks = 0;
  int errors = 0;

  // Model: words waiting per channel, last word written per channel, push count.
  logic [31:0] q [8][$];
  logic [31:0] lastdata [8];
  int          mcnt;

  demux832 #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      q[k].delete();
      lastdata[k] = 32'h0;
    end
    mcnt = 0;
  endtask

  task automatic check_outputs();
    logic [7:0]   ev;
    logic [255:0] ed;
    for (int k = 0; k < 8; k++) begin
      ev[k] = (q[k].size() != 0);
      ed[k*32 +: 32] = lastdata[k];
    end
    chk("out_valid", {248'h0, out_valid}, {248'h0, ev});
    chk("out_data", out_data, ed);
    chk("acc_cnt", {240'h0, acc_cnt}, {240'h0, 16'(mcnt)});
  endtask

  // Called at posedge+1: drive, check handshake and delivered order, clock, check state.
  task automatic cycle(input logic v, input logic [2:0] s, input logic [31:0] d,
                       input logic [7:0] ordy, output logic accepted);
    logic exp_rdy;
    in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
    #1;
    exp_rdy = (q[s].size() == 0) || ordy[s];
    chk("in_ready", {255'h0, in_ready}, {255'h0, exp_rdy});
    for (int k = 0; k < 8; k++) begin
      if (q[k].size() != 0 && ordy[k]) begin
        chk("pop_order", {224'h0, out_data[k*32 +: 32]}, {224'h0, q[k][0]});
      end
    end
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (q[k].size() != 0 && ordy[k]) void'(q[k].pop_front());
    end
    accepted = v && exp_rdy;
    if (accepted) begin
      q[s].push_back(d);
      lastdata[s] = d;
      mcnt = (mcnt + 1) % 65536;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    logic        acc;
    logic        pv;
    logic [2:0]  ps;
    logic [31:0] pd;

    reset = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 32'h0; out_ready = 8'h00;
    model_clear();
    #1;
    chk("reset_ready", {255'h0, in_ready}, {255'h0, 1'b1});
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check_outputs();

    // Single route.
    cycle(1'b1, 3'd5, 32'hDEADBEEF, 8'h00, acc);
    chk("single_valid", {248'h0, out_valid}, {248'h0, 8'b0010_0000});
    chk("single_data", {224'h0, out_data[5*32 +: 32]}, {224'h0, 32'hDEADBEEF});
    chk("single_cnt", {240'h0, acc_cnt}, {240'h0, 16'd1});

    // Backpressure isolation on channel 2.
    cycle(1'b1, 3'd2, 32'h2222_0001, 8'h00, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 3'd2, 32'h2222_0002, 8'h00, acc);
      chk("bp_blocked", {255'h0, acc}, {255'h0, 1'b0});
    end
    chk("bp_hold", {224'h0, out_data[2*32 +: 32]}, {224'h0, 32'h2222_0001});
    cycle(1'b1, 3'd6, 32'h6666_0006, 8'h00, acc);
    chk("bp_other", {255'h0, out_valid[6]}, {255'h0, 1'b1});

    // Streaming on channel 0.
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 3'd0, 32'(i), 8'h01, acc);
      chk("stream_data", {224'h0, out_data[31:0]}, {224'h0, 32'(i)});
      chk("stream_valid", {255'h0, out_valid[0]}, {255'h0, 1'b1});
    end
    chk("stream_cnt", {240'h0, acc_cnt}, {240'h0, 16'd7});

    // Simultaneous push and pop on channel 7.
    cycle(1'b1, 3'd7, 32'hA, 8'h00, acc);
    cycle(1'b1, 3'd7, 32'hB, 8'h80, acc);
    chk("pp_data", {224'h0, out_data[7*32 +: 32]}, {224'h0, 32'hB});
    chk("pp_valid", {255'h0, out_valid[7]}, {255'h0, 1'b1});

    // Randomized traffic honouring the hold-until-accepted rule.
    pv = 1'b0; ps = 3'd0; pd = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        ps = 3'($urandom_range(0, 7));
        pd = $urandom;
      end
      cycle(pv, ps, pd, 8'($urandom), acc);
      if (acc) pv = 1'b0;
    end

    // Asynchronous reset mid-stream with channel 3 full.
    cycle(1'b1, 3'd3, 32'h3333_3333, 8'h00, acc);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_valid", {248'h0, out_valid}, {248'h0, 8'h00});
    chk("rst_cnt", {240'h0, acc_cnt}, {240'h0, 16'h0000});
    chk("rst_data", out_data, 256'h0);
    chk("rst_ready", {255'h0, in_ready}, {255'h0, 1'b1});
    @(posedge clk); #1;
    reset = 1'b0;

    // Counter wrap: 65536 pushes across rotating channels.
    for (int i = 0; i < 65536; i++) begin
      cycle(1'b1, 3'(i % 8), 32'(i) ^ 32'h5A5A_0000, 8'hFF, acc);
    end
    chk("wrap_cnt", {240'h0, acc_cnt}, {240'h0, 16'h0000});
    chk("wrap_last", {224'h0, out_data[7*32 +: 32]}, {224'h0, 32'(65535) ^ 32'h5A5A_0000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux832.md
# demux832

One-to-eight buffered word distributor: the scatter counterpart of the eight-way word selector used on the P8 datapath and bridge. Each accepted 32-bit input word is routed by a 3-bit channel select into one of eight single-entry output buffers. Each buffer independently presents the word to its sink under a valid/ready handshake. It sits between the CPU bridge write path and up to eight peripheral or write-back sinks, so that a stalled sink does not block the others.

## Interface
- WIDTH, 32, data word width per channel.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  a word is offered on in_data/in_sel.
- in_ready  output  1  the block accepts the offered word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  3  destination channel, 0..7.
- out_valid  output  8  bit k: channel k buffer holds an undelivered word.
- out_ready  input  8  bit k: sink k takes the word this cycle.
- out_data  output  8*WIDTH  channel k word on bits [k*WIDTH +: WIDTH].
- acc_cnt  output  16  total words accepted since reset; wraps at 16 bits.

## Operation
- Per channel k: a WIDTH-bit data register and a full flag. out_valid[k] = full[k]. out_data slice k = data register k.
- Push condition: push = in_valid & in_ready. Words enter only channel in_sel.
- Pop condition for channel k: pop[k] = full[k] & out_ready[k].
- in_ready = ~full[in_sel] | out_ready[in_sel]. This is combinational from in_sel and out_ready only; it does not depend on in_valid.
- Channel k state update on a rising edge:
  - push to k, no pop: data register loads in_data; full becomes 1.
  - pop, no push to k: full becomes 0; data register keeps its value.
  - push to k and pop in the same cycle: data register loads in_data; full stays 1. This allows back-to-back streaming at one word per cycle.
  - neither: hold.
- Pushes and pops on different channels in the same cycle are fully independent.
- acc_cnt increments by 1 on every push. 16'hFFFF + 1 wraps to 0.
- in_valid with in_ready=0: nothing changes. The source must hold in_data and in_sel stable until the word is accepted.
- out_ready[k] asserted while full[k]=0 has no effect.
- No state machine beyond the eight full flags; each channel has two states, EMPTY and FULL, with the transitions above.

## Timing
- Reset (asynchronous assert): full = 0, out_valid = 8'h00, all data registers = 0, acc_cnt = 0.
  - Reset asserted mid-operation discards every buffered word at once, without waiting for a clock edge.
  - in_ready is 1 while reset is high.
- First rising edge after reset release: normal operation.
- Latency: a word pushed at edge N is visible on out_data with out_valid high immediately after edge N (one cycle).
- Throughput: one word per cycle total. A channel whose sink holds out_ready=1 sustains one word per cycle.
- Full channel with out_ready=0: in_ready is 0 for that select only. Words for other channels are still accepted.
- Delivered data: out_data slice k holds its last value after a pop until the next push to k.

## Test plan
- Reset/idle: assert reset mid-stream with channel 3 full -> immediately out_valid=8'h00, acc_cnt=0, out_data all zero, in_ready=1.
- Single route: push 32'hDEADBEEF with in_sel=5, all out_ready=0 -> the next cycle out_valid=8'b0010_0000, slice 5 = 32'hDEADBEEF, acc_cnt=1.
- Backpressure isolation: channel 2 full, out_ready[2]=0.
  - Offer with in_sel=2 -> in_ready=0; no state change for 3 cycles.
  - Offer with in_sel=6 -> accepted, out_valid[6]=1.
- Streaming: channel 0 with out_ready[0]=1 held, push 1,2,3,4 on consecutive cycles -> in_ready stays 1, slice 0 shows 1,2,3,4 on consecutive cycles, out_valid[0] stays 1, acc_cnt=4.
- Simultaneous push/pop: channel 7 holds 32'hA, out_ready[7]=1, push 32'hB to 7 in the same cycle -> after the edge slice 7 = 32'hB, out_valid[7]=1, no word lost or duplicated.
- Counter wrap: perform 65536 pushes across rotating channels with all out_ready=1 -> acc_cnt returns to 0, and every channel receives its words in order.
